// File: rtl/sram_async_ctrl.sv
// Single-port controller for an external asynchronous SRAM (ce_n/we_n/oe_n).
// Host side is a req/ready port; every SRAM pin and host output is registered.
module sram_async_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 18,
    parameter int WR_WAIT    = 2,
    parameter int RD_WAIT    = 2,
    parameter int TURNAROUND = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic [DATA_WIDTH-1:0]   sram_dq_o,
    input  logic [DATA_WIDTH-1:0]   sram_dq_i,
    output logic                    sram_dq_oe,
    output logic                    sram_ce_n,
    output logic                    sram_we_n,
    output logic                    sram_oe_n,
    output logic [DATA_WIDTH/8-1:0] sram_bw_n
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACCESS,
        TURN
    } state_t;

    localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
    localparam logic [3:0] TA_CNT = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_bw_n  <= '1;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && ready) begin
                        ready     <= 1'b0;
                        sram_a    <= addr;
                        sram_ce_n <= 1'b0;
                        if (wr) begin
                            state      <= WR_SETUP;
                            sram_dq_o  <= wdata;
                            sram_dq_oe <= 1'b1;
                            sram_bw_n  <= ~be;
                        end else begin
                            state     <= RD_ACCESS;
                            sram_oe_n <= 1'b0;
                            sram_bw_n <= '0;
                            cnt       <= RD_CNT;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt       <= WR_CNT;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    // we_n rises one cycle before ce_n/dq_oe so data and address are held past the strobe
                    if (cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_bw_n  <= '1;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
                RD_ACCESS: begin
                    if (cnt == 4'd0) begin
                        rdata     <= sram_dq_i;
                        rvalid    <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_bw_n <= '1;
                        if (TURNAROUND == 0) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt   <= TA_CNT;
                            state <= TURN;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                TURN: begin
                    // SRAM output drivers need time to release dq before we may drive it
                    if (cnt == 4'd0) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_no_contention: assert property (@(posedge clk) disable iff (!rst_n)
        !(sram_dq_oe && !sram_oe_n));
    a_we_qualified: assert property (@(posedge clk) disable iff (!rst_n)
        !sram_we_n |-> (!sram_ce_n && sram_dq_oe));
    a_we_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $changed(sram_we_n)) |-> $stable(sram_a));

endmodule
